// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Holds FSM encodings, write-back/forward selects, RAW and forward functions.
package pipe_ctrl_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  function automatic logic raw_hit(
    input logic       we,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return we && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) ||
            (rs2_used && (rs2 == rd)));
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_EXMEM;
    if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller.
// master = pipeline/decode side, slave = controller. Forward ports need FORWARD_EN.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_rs1_used;
  logic             ID_rs2_used;
  logic [4:0]       EX_rd;
  logic             EX_RegWrite;
  logic [1:0]       EX_MemtoReg;
  logic [4:0]       MEM_rd;
  logic             MEM_RegWrite;
  logic             EX_redirect;
  logic             MEM_req;
  logic             MIO_ready;
  logic             PC_en;
  logic             IF_ID_en;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_en;
  logic             MEM_WB_en;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
`ifdef FORWARD_EN
  logic [4:0]       EX_rs1;
  logic [4:0]       EX_rs2;
  logic [4:0]       WB_rd;
  logic             WB_RegWrite;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;

  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    output EX_rd, EX_RegWrite, EX_MemtoReg,
    output MEM_rd, MEM_RegWrite,
    output EX_redirect, MEM_req, MIO_ready,
    output EX_rs1, EX_rs2, WB_rd, WB_RegWrite,
    input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush,
    input  EX_MEM_en, MEM_WB_en, mem_timeout,
    input  stall_cnt, flush_cnt, wait_cnt,
    input  ForwardA, ForwardB
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    input  EX_rd, EX_RegWrite, EX_MemtoReg,
    input  MEM_rd, MEM_RegWrite,
    input  EX_redirect, MEM_req, MIO_ready,
    input  EX_rs1, EX_rs2, WB_rd, WB_RegWrite,
    output PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush,
    output EX_MEM_en, MEM_WB_en, mem_timeout,
    output stall_cnt, flush_cnt, wait_cnt,
    output ForwardA, ForwardB
  );
`else
  modport master (
    output ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    output EX_rd, EX_RegWrite, EX_MemtoReg,
    output MEM_rd, MEM_RegWrite,
    output EX_redirect, MEM_req, MIO_ready,
    input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush,
    input  EX_MEM_en, MEM_WB_en, mem_timeout,
    input  stall_cnt, flush_cnt, wait_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_rs1_used, ID_rs2_used,
    input  EX_rd, EX_RegWrite, EX_MemtoReg,
    input  MEM_rd, MEM_RegWrite,
    input  EX_redirect, MEM_req, MIO_ready,
    output PC_en, IF_ID_en, IF_ID_flush, ID_EX_flush,
    output EX_MEM_en, MEM_WB_en, mem_timeout,
    output stall_cnt, flush_cnt, wait_cnt
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance statistics.
// Ports: clk, rst (sync, active-high), inc, cnt (sticks at all-ones).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard/stall/flush sequencer with memory-wait FSM.
// Ports: clk, rst (sync, active-high), bus (slave). FORWARD_EN: load-use stall + forwarding.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;

  localparam int TW = $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] TMAX = TW'(WAIT_MAX);

  logic [0:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tmo_q, tmo_d;
  logic          hzd_ex;
  logic          data_stall;
  logic          hold;
  logic          do_redir;
  logic          do_stall;
  logic          stall_inc;
  logic          flush_inc;
  logic          wait_inc;

  assign hzd_ex = raw_hit(bus.EX_RegWrite, bus.EX_rd,
                          bus.ID_rs1, bus.ID_rs1_used,
                          bus.ID_rs2, bus.ID_rs2_used);

`ifdef FORWARD_EN
  assign data_stall = hzd_ex &&
                      (bus.EX_MemtoReg == MEMTOREG_LOAD);

  assign bus.ForwardA = fwd_sel(bus.MEM_RegWrite, bus.MEM_rd,
                                bus.WB_RegWrite, bus.WB_rd,
                                bus.EX_rs1);
  assign bus.ForwardB = fwd_sel(bus.MEM_RegWrite, bus.MEM_rd,
                                bus.WB_RegWrite, bus.WB_rd,
                                bus.EX_rs2);
`else
  logic hzd_mem;
  logic unused_memtoreg;

  assign hzd_mem = raw_hit(bus.MEM_RegWrite, bus.MEM_rd,
                           bus.ID_rs1, bus.ID_rs1_used,
                           bus.ID_rs2, bus.ID_rs2_used);
  assign data_stall = hzd_ex | hzd_mem;
  assign unused_memtoreg = ^bus.EX_MemtoReg;
`endif

  // In MEM_WAIT the access is still pending, so only ready releases it.
  assign hold = (state_q == ST_MEM_WAIT) ? !bus.MIO_ready
              : (bus.MEM_req && !bus.MIO_ready);
  assign do_redir = !hold && bus.EX_redirect;
  assign do_stall = !hold && !bus.EX_redirect && data_stall;

  always_comb begin
    bus.PC_en       = 1'b1;
    bus.IF_ID_en    = 1'b1;
    bus.IF_ID_flush = 1'b0;
    bus.ID_EX_flush = 1'b0;
    bus.EX_MEM_en   = 1'b1;
    bus.MEM_WB_en   = 1'b1;
    state_d         = ST_RUN;
    timer_d         = '0;
    tmo_d           = tmo_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    wait_inc        = 1'b0;
    unique case (1'b1)
      hold: begin
        bus.PC_en     = 1'b0;
        bus.IF_ID_en  = 1'b0;
        bus.EX_MEM_en = 1'b0;
        bus.MEM_WB_en = 1'b0;
        state_d       = ST_MEM_WAIT;
        wait_inc      = 1'b1;
        if (state_q == ST_RUN)
          timer_d = TW'(1);
        else if (timer_q == TMAX)
          timer_d = timer_q;
        else
          timer_d = timer_q + 1'b1;
        if (timer_d == TMAX)
          tmo_d = 1'b1;
      end
      do_redir: begin
        bus.IF_ID_flush = 1'b1;
        bus.ID_EX_flush = 1'b1;
        flush_inc       = 1'b1;
      end
      do_stall: begin
        bus.PC_en       = 1'b0;
        bus.IF_ID_en    = 1'b0;
        bus.ID_EX_flush = 1'b1;
        stall_inc       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.mem_timeout = tmo_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (bus.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .cnt (bus.wait_cnt)
  );
endmodule
